// File: rtl/riscv_pkg.sv
// Shared definitions for the core front end: the canonical NOP, the base
// opcode values seen by the control unit, and the fetch FSM state type.
package riscv_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: valid/ready request channel plus an in-order
// response that arrives some cycles after the accepted request.
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for a fetched {instr, pc} that arrived while the
// IF/ID register was occupied and stalled. Clear beats load beats drain.
module fetch_skid_buffer
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            full,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out
);

  // Capture on load, release on drain, drop everything on clear (redirect).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= 1'b0;
      instr_out <= NOP;
      pc_out    <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full      <= 1'b1;
      instr_out <= instr_in;
      pc_out    <= pc_in;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns pc_f, issues one outstanding word request
// at a time, fills the IF/ID register (with a one-entry skid for stalls) and
// applies branch/jump redirects from the control unit.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcsrc,
  input  logic            jbmux,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  input  logic            stall,
  fetch_stage_if.master   imem,
  output logic            valid_d,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic            funct7
);

  localparam logic [XLEN-1:0] WORD_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_t    state;
  logic [XLEN-1:0] pc_f;

  logic            redirect;
  logic            advance;
  logic            resp_in;
  logic            req_fire;
  logic [XLEN-1:0] target;

  logic            skid_full;
  logic            skid_load;
  logic            skid_drain;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;

  // A redirect is only honoured for a live decode instruction that is moving on.
  assign redirect = valid_d && pcsrc && !stall;
  assign advance  = !valid_d || !stall;
  assign resp_in  = (state == WAIT) && imem.imem_resp_valid;
  assign req_fire = imem.imem_req_valid && imem.imem_req_ready;

  // JALR clears bit 0 and branches clear nothing, but both are forced to a
  // word boundary, so one mask over either source covers both cases.
  assign target = (jbmux ? alu_result : (pc_d + imm_ext)) & ALIGN_MASK;

  assign imem.imem_req_valid = (state == REQ) && !skid_full;
  assign imem.imem_req_addr  = pc_f;

  assign skid_load  = resp_in && !redirect && !advance;
  assign skid_drain = skid_full && advance && !redirect;

  fetch_skid_buffer #(.XLEN(XLEN)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .drain     (skid_drain),
    .clear     (redirect),
    .instr_in  (imem.imem_resp_data),
    .pc_in     (pc_f),
    .full      (skid_full),
    .instr_out (skid_instr),
    .pc_out    (skid_pc)
  );

  // Request FSM and fetch PC; a redirect overrides whatever pc_f update the
  // state would otherwise make, and sends an unanswered request to DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc_f  <= RESET_PC;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (req_fire) state <= redirect ? DRAIN : WAIT;
        end
        WAIT: begin
          if (imem.imem_resp_valid) begin
            state <= REQ;
            pc_f  <= pc_f + WORD_STEP;
          end else if (redirect) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (imem.imem_resp_valid) state <= REQ;
        end
        default: state <= IDLE;
      endcase
      if (redirect) pc_f <= target;
    end
  end

  // IF/ID register: flush on redirect, otherwise refill from skid first,
  // then from a fresh response, else bubble with a NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_d   <= 1'b0;
      instr_d   <= NOP;
      pc_d      <= '0;
      pcplus4_d <= WORD_STEP;
    end else if (redirect) begin
      valid_d <= 1'b0;
      instr_d <= NOP;
    end else if (advance) begin
      if (skid_full) begin
        valid_d   <= 1'b1;
        instr_d   <= skid_instr;
        pc_d      <= skid_pc;
        pcplus4_d <= skid_pc + WORD_STEP;
      end else if (resp_in) begin
        valid_d   <= 1'b1;
        instr_d   <= imem.imem_resp_data;
        pc_d      <= pc_f;
        pcplus4_d <= pc_f + WORD_STEP;
      end else begin
        valid_d <= 1'b0;
        instr_d <= NOP;
      end
    end
  end

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign funct7 = instr_d[30];

endmodule
